// File: rtl/instrument_pkg.sv
// Shared constants and state type for the instrument frame decoder.
// Frames are SYNC, ADDR, DATA, CHK with CHK = ADDR ^ DATA.
package instrument_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ADDR_BASS = 8'h00;
    localparam logic [7:0] ADDR_DRUM = 8'h01;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        CHK
    } frame_state_t;

    function automatic logic frame_chk_ok(input logic [7:0] addr,
                                          input logic [7:0] data,
                                          input logic [7:0] chk);
        return chk == (addr ^ data);
    endfunction

    function automatic logic is_valid_addr(input logic [7:0] addr);
        return (addr == ADDR_BASS) || (addr == ADDR_DRUM);
    endfunction

endpackage

// File: rtl/instrument_gap_timer.sv
// Inter-byte gap timer: counts while a frame is open and pulses expired
// on the cycle the count sits at TIMEOUT_CYCLES-1 with no byte arriving.
module instrument_gap_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // A byte arriving on the limit cycle wins over the timeout.
    assign expired = run && !clear && (cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || !run || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/instrument_frame_ctrl.sv
// Decodes SYNC/ADDR/DATA/CHK frames from the UART byte stream and updates
// the bass or drum register; bad, unknown or stalled frames are rejected.
module instrument_frame_ctrl
    import instrument_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] bass,
    output logic [7:0] drum,
    output logic       bass_upd,
    output logic       drum_upd,
    output logic       frame_err,
    output logic [7:0] err_count,
    output logic       busy
);

    frame_state_t state_q, state_d;
    logic [7:0]   addr_q, addr_d;
    logic [7:0]   data_q, data_d;
    logic [7:0]   bass_d, drum_d, err_count_d;
    logic         bass_upd_d, drum_upd_d, frame_err_d;
    logic         gap_expired;

    instrument_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_valid),
        .run    (state_q != IDLE),
        .expired(gap_expired)
    );

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            bass      <= '0;
            drum      <= '0;
            bass_upd  <= 1'b0;
            drum_upd  <= 1'b0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            bass      <= bass_d;
            drum      <= drum_d;
            bass_upd  <= bass_upd_d;
            drum_upd  <= drum_upd_d;
            frame_err <= frame_err_d;
            err_count <= err_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        bass_d      = bass;
        drum_d      = drum;
        bass_upd_d  = 1'b0;
        drum_upd_d  = 1'b0;
        frame_err_d = 1'b0;

        if (rx_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = ADDR;
                    end
                end
                ADDR: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = ADDR;
                    end else if (is_valid_addr(rx_data)) begin
                        addr_d  = rx_data;
                        state_d = DATA;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
                DATA: begin
                    data_d  = rx_data;
                    state_d = CHK;
                end
                CHK: begin
                    state_d = IDLE;
                    if (frame_chk_ok(addr_q, data_q, rx_data)) begin
                        if (addr_q == ADDR_BASS) begin
                            bass_d     = data_q;
                            bass_upd_d = 1'b1;
                        end else begin
                            drum_d     = data_q;
                            drum_upd_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (gap_expired) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
        end

        // Counter lands in the same cycle frame_err goes high.
        if (frame_err_d && (err_count != 8'hFF)) begin
            err_count_d = err_count + 8'd1;
        end else begin
            err_count_d = err_count;
        end
    end

endmodule

// File: tb/tb_instrument_frame_ctrl.sv
// Self-checking bench: a byte-queue frame model checked against the DUT every
// cycle, plus hand-computed expectations from the directed scenarios.
module tb_instrument_frame_ctrl;

    localparam int unsigned TO = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] bass, drum, err_count;
    logic       bass_upd, drum_upd, frame_err, busy;

    instrument_frame_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .bass     (bass),
        .drum     (drum),
        .bass_upd (bass_upd),
        .drum_upd (drum_upd),
        .frame_err(frame_err),
        .err_count(err_count),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference model: the open frame is just the list of bytes accepted so far.
    logic [7:0] fb[$];
    int         gap = 0;
    logic [7:0] m_bass = 0, m_drum = 0, m_errc = 0;
    logic       m_bupd = 0, m_dupd = 0, m_err = 0;

    always @(posedge clk) begin
        m_bupd = 0; m_dupd = 0; m_err = 0;
        if (rst) begin
            fb.delete(); gap = 0; m_bass = 0; m_drum = 0; m_errc = 0;
        end else begin
            if (rx_valid) begin
                gap = 0;
                case (fb.size())
                    0: if (rx_data == 8'hA5) fb.push_back(rx_data);
                    1: begin
                        if (rx_data == 8'h00 || rx_data == 8'h01) fb.push_back(rx_data);
                        else if (rx_data != 8'hA5) begin m_err = 1; fb.delete(); end
                    end
                    2: fb.push_back(rx_data);
                    default: begin
                        if ((fb[1] ^ fb[2]) == rx_data) begin
                            if (fb[1] == 8'h00) begin m_bass = fb[2]; m_bupd = 1; end
                            else begin m_drum = fb[2]; m_dupd = 1; end
                        end else m_err = 1;
                        fb.delete();
                    end
                endcase
            end else if (fb.size() != 0) begin
                gap++;
                if (gap == TO) begin m_err = 1; fb.delete(); gap = 0; end
            end
            if (m_err && m_errc != 8'd255) m_errc = m_errc + 8'd1;
        end
    end

    int n_bupd = 0, n_dupd = 0, n_err = 0;

    always @(negedge clk) begin
        check("bass", bass, m_bass);
        check("drum", drum, m_drum);
        check("err_count", err_count, m_errc);
        check("bass_upd", bass_upd, m_bupd);
        check("drum_upd", drum_upd, m_dupd);
        check("frame_err", frame_err, m_err);
        check("busy", busy, fb.size() != 0);
        n_bupd += int'(bass_upd === 1'b1);
        n_dupd += int'(drum_upd === 1'b1);
        n_err  += int'(frame_err === 1'b1);
    end

    // Called at a falling edge; byte is taken on the next rising edge.
    task automatic send_byte(input logic [7:0] b, input int g);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = $urandom_range(0, 255);
        repeat (g) @(negedge clk);
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send_byte(8'hA5, 0); send_byte(a, 0); send_byte(d, 0); send_byte(c, 0);
    endtask

    int b0, d0, e0, first_k, err_seen, r, g;
    logic [7:0] ra, rd;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_bass", bass, 8'h00);
        check("rst_drum", drum, 8'h00);
        check("rst_errc", err_count, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_pulses", {bass_upd, drum_upd, frame_err}, 3'b000);
        @(negedge clk);

        b0 = n_bupd;
        send4(8'h00, 8'h3C, 8'h3C);
        #1;
        check("f1_bass", bass, 8'h3C);
        check("f1_model_bass", m_bass, 8'h3C);
        check("f1_drum", drum, 8'h00);
        check("f1_errc", err_count, 8'h00);
        check("f1_bupd_count", n_bupd - b0, 1);

        d0 = n_dupd;
        send4(8'h01, 8'h7F, 8'h7E);
        #1;
        check("f2_drum", drum, 8'h7F);
        send4(8'h01, 8'hA5, 8'hA4);
        #1;
        check("f3_drum_a5", drum, 8'hA5);
        check("f3_model_drum", m_drum, 8'hA5);
        check("f23_dupd_count", n_dupd - d0, 2);

        send4(8'h00, 8'h10, 8'h11);
        check("badchk_err", frame_err, 1'b1);
        check("badchk_errc", err_count, 8'd1);
        check("badchk_bass", bass, 8'h3C);
        send_byte(8'hA5, 0); send_byte(8'h07, 0);
        check("badaddr_err", frame_err, 1'b1);
        check("badaddr_errc", err_count, 8'd2);
        check("badaddr_model_errc", m_errc, 8'd2);

        send_byte(8'h12, 0); send_byte(8'hA5, 0); send_byte(8'hA5, 0); send_byte(8'hA5, 0);
        send_byte(8'h00, 0); send_byte(8'h55, 0); send_byte(8'h55, 0);
        #1;
        check("resync_bass", bass, 8'h55);
        check("resync_errc", err_count, 8'd2);

        // Timeout: error pulse exactly TO cycles after the last byte.
        send_byte(8'hA5, 0); send_byte(8'h00, 0);
        first_k = -1; err_seen = 0;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (frame_err === 1'b1) begin
                err_seen++;
                if (first_k < 0) first_k = k;
            end
        end
        check("timeout_cycle", first_k, TO);
        check("timeout_pulses", err_seen, 1);
        check("timeout_errc", err_count, 8'd3);
        b0 = n_bupd;
        send_byte(8'h55, 0); send_byte(8'h55, 0);
        #1;
        check("post_timeout_no_upd", n_bupd - b0, 0);
        check("post_timeout_bass", bass, 8'h55);
        @(negedge clk);

        // Byte landing on the expiry cycle keeps the frame alive.
        e0 = n_err;
        send_byte(8'hA5, 0); send_byte(8'h00, TO - 1);
        send_byte(8'h5A, 0); send_byte(8'h5A, 0);
        #1;
        check("edge_no_err", n_err - e0, 0);
        check("edge_bass", bass, 8'h5A);
        @(negedge clk);

        send_byte(8'hA5, 0); send_byte(8'h01, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_bass", bass, 8'h00);
        check("midrst_drum", drum, 8'h00);
        check("midrst_errc", err_count, 8'h00);
        check("midrst_busy", busy, 1'b0);
        @(negedge clk);
        send4(8'h00, 8'h22, 8'h22);
        #1;
        check("after_rst_bass", bass, 8'h22);
        @(negedge clk);

        // Randomised traffic against the model.
        for (int n = 0; n < 250; n++) begin
            r  = $urandom_range(0, 9);
            ra = 8'($urandom_range(0, 1));
            rd = 8'($urandom_range(0, 255));
            g  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : 0;
            case (r)
                0, 1, 2, 3, 4: begin
                    send_byte(8'hA5, g); send_byte(ra, g); send_byte(rd, g); send_byte(ra ^ rd, g);
                end
                5: begin
                    send_byte(8'hA5, g); send_byte(ra, g); send_byte(rd, g);
                    send_byte(ra ^ rd ^ 8'($urandom_range(1, 255)), g);
                end
                6: begin send_byte(8'hA5, g); send_byte(8'($urandom_range(2, 255)), g); end
                7: send_byte(rd, g);
                8: begin
                    send_byte(8'hA5, 0);
                    if (rd[0]) send_byte(ra, 0);
                    repeat ($urandom_range(TO - 3, TO + 3)) @(negedge clk);
                end
                default: begin
                    if (rd[7:5] == 3'd0) begin
                        rst = 1'b1; @(negedge clk); rst = 1'b0;
                    end else send_byte(8'hA5, g);
                end
            endcase
        end

        rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
        e0 = n_err;
        for (int n = 0; n < 300; n++) begin
            send_byte(8'hA5, 0); send_byte(8'h07, 0);
        end
        #1;
        check("sat_errc", err_count, 8'd255);
        check("sat_model_errc", m_errc, 8'd255);
        check("sat_err_pulses", n_err - e0, 300);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instrument_frame_ctrl.md
# instrument_frame_ctrl

Frame decoder and register controller between the UART `async_receiver` and the instrument outputs. It turns the raw byte stream into addressed 4-byte frames (SYNC, ADDR, DATA, CHK) and updates either the `bass` or the `drum` register. Every frame is checksum-validated and bounded by an inter-byte timeout. Corrupt, unknown or stalled frames never disturb the output registers.

## Interface
- `TIMEOUT_CYCLES`, default 50000: maximum clk cycles allowed between consecutive bytes of one frame.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous reset, active-high.
- `rx_valid` in 1: one-cycle strobe from `async_receiver` (`RxD_data_ready`).
- `rx_data` in 8: received byte; valid only when `rx_valid`=1.
- `bass` out 8: bass register.
- `drum` out 8: drum register.
- `bass_upd` out 1: one-cycle pulse when `bass` takes a new value.
- `drum_upd` out 1: one-cycle pulse when `drum` takes a new value.
- `frame_err` out 1: one-cycle pulse when a frame is rejected.
- `err_count` out 8: count of rejected frames; saturates at 255.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- Frame format: SYNC=0xA5, ADDR (0x00=bass, 0x01=drum), DATA, CHK = ADDR ^ DATA.
- States: IDLE, ADDR, DATA, CHK. State changes only on `rx_valid` or on timeout.
- IDLE:
  - `rx_valid` with byte 0xA5 → ADDR.
  - Any other byte is discarded silently, with no error.
- ADDR:
  - 0xA5 → stay in ADDR (repeated sync).
  - 0x00 or 0x01 → latch the address and go to DATA.
  - Any other byte → `frame_err`, go to IDLE.
- DATA: any byte, including 0xA5, is latched as data → CHK.
- CHK: any byte; the next state is always IDLE.
  - If byte == latched ADDR ^ DATA: write DATA to the addressed register and pulse the matching `*_upd`.
  - Otherwise: pulse `frame_err`, with no register write.
- Gap timer:
  - Cleared on every `rx_valid`. Held at 0 while in IDLE.
  - Counts every cycle in ADDR, DATA and CHK.
  - When it reaches `TIMEOUT_CYCLES-1` with no `rx_valid`: pulse `frame_err`, go to IDLE, and discard any partial frame.
- Timeout and `rx_valid` in the same cycle: the byte is processed normally and the timer is cleared. No timeout occurs.
- `err_count` increments on every `frame_err` pulse and holds at 255.
- Outputs `bass` and `drum` hold their value indefinitely between valid frames.

## Timing
- Reset values:
  - `bass`=0x00, `drum`=0x00, `err_count`=0.
  - `bass_upd`, `drum_upd`, `frame_err`, `busy` = 0.
  - State IDLE, timer 0.
- `rst` has priority over everything, in any state. A partial frame is dropped and no pulse is produced in that cycle.
- Latency: the register update and its `*_upd` pulse are visible on the cycle after the CHK byte's `rx_valid` (one registered stage).
- `frame_err` for a bad ADDR or bad CHK is asserted the cycle after the offending `rx_valid`. For a timeout it is asserted the cycle after the count reaches the limit.
- `err_count` reflects an error in the same cycle `frame_err` is high.
- Pulses are exactly one cycle. At most one of `bass_upd`, `drum_upd`, `frame_err` is high in any cycle.
- Back-to-back frames: the SYNC byte of the next frame may arrive on the cycle right after the CHK byte. The `rx_valid` spacing from the UART is never below 1 cycle.
- Timer width is `$clog2(TIMEOUT_CYCLES)`.

## Structure
- Shared package `instrument_pkg`:
  - `SYNC_BYTE`=8'hA5, `ADDR_BASS`=8'h00, `ADDR_DRUM`=8'h01.
  - State enum `frame_state_t` {IDLE, ADDR, DATA, CHK}.
- Sub-module `instrument_gap_timer`:
  - Parameter `TIMEOUT_CYCLES`.
  - Inputs: `clk`, `rst`, `clear`, `run`.
  - Output: `expired`, a one-cycle pulse.
- Top level: `async_receiver` → `instrument_frame_ctrl`. This block replaces the direct `RxD_data` → `bass` assignment in the instrument top level.

## Test plan
- Reset, then bytes A5 00 3C 3C → `bass_upd` pulses once and `bass`=0x3C. `drum`=0x00, `err_count`=0.
- Bytes A5 01 7F 7E → `drum`=0x7F with a `drum_upd` pulse. Then A5 01 A5 A4 → `drum`=0xA5, proving DATA=0xA5 is accepted.
- Bytes A5 00 10 11 (bad CHK) → `frame_err` pulse, `err_count`=1, `bass` unchanged. Bytes A5 07 → `frame_err` at the ADDR byte, `err_count`=2.
- Leading garbage plus repeated sync, bytes 12 A5 A5 A5 00 55 55 → no error and `bass`=0x55.
- With `TIMEOUT_CYCLES`=100: send A5 00, then idle 150 cycles → `frame_err` exactly 100 cycles after the 00 byte. A following 55 55 produces no update.
- Timer edge: deliver a byte exactly on the expiry cycle → no error and the frame completes. Then assert `rst` mid-frame (after A5 01) → all outputs 0 and the next A5 00 22 22 sets `bass`=0x22. Then force 300 bad frames → `err_count` saturates at 255.
